// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

   localparam int NIBBLE = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_la_adder4.sv
// 4-bit carry-lookahead adder slice with group propagate output.
module la_adder4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o,
   output logic       pout_o
);

   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & cin_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

   assign cout_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (&p & cin_i);
   assign pout_o = &p;
   assign sum_o  = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder: one lookahead slice reused per cycle, LSB nibble first,
// with valid/ready handshakes on operands and result.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             all_prop
);

   localparam int N     = WIDTH / NIBBLE;
   localparam int IDX_W = idx_width(N);

   state_e                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [N-1:0][NIBBLE-1:0]     a_q, a_d;
   logic [N-1:0][NIBBLE-1:0]     b_q, b_d;
   logic [N-1:0][NIBBLE-1:0]     sum_q, sum_d;
   logic                         carry_q, carry_d;
   logic                         prop_q, prop_d;
   logic                         cout_q, cout_d;
   logic                         ovf_q, ovf_d;
   logic                         all_prop_q, all_prop_d;

   logic [NIBBLE-1:0]            slice_sum;
   logic                         slice_cout;
   logic                         slice_pout;
   logic                         last_step;

   la_adder4 u_slice (
      .a_i    (a_q[idx_q]),
      .b_i    (b_q[idx_q]),
      .cin_i  (carry_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout),
      .pout_o (slice_pout)
   );

   assign last_step = (idx_q == IDX_W'(N - 1));

   // Visible results live in their own registers so a new accept cannot disturb them.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      carry_d    = carry_q;
      prop_d     = prop_q;
      cout_d     = cout_q;
      ovf_d      = ovf_q;
      all_prop_d = all_prop_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               prop_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[idx_q] = slice_sum;
            carry_d      = slice_cout;
            prop_d       = prop_q & slice_pout;
            if (last_step) begin
               cout_d     = slice_cout;
               all_prop_d = prop_q & slice_pout;
               ovf_d      = (a_q[N-1][NIBBLE-1] ~^ b_q[N-1][NIBBLE-1])
                          & (slice_sum[NIBBLE-1] ^ a_q[N-1][NIBBLE-1]);
               state_d    = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         prop_q     <= 1'b0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
         all_prop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sum_q      <= sum_d;
         carry_q    <= carry_d;
         prop_q     <= prop_d;
         cout_q     <= cout_d;
         ovf_q      <= ovf_d;
         all_prop_q <= all_prop_d;
      end
   end

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign ovf      = ovf_q;
   assign all_prop = all_prop_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed vectors and corners at WIDTH=16, random ops at 16 and 4.
module tb_nibble_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16;
   logic [15:0] a16, b16, sum16;
   logic        cout16, ovf16, prop16;

   logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4;
   logic [3:0]  a4, b4, sum4;
   logic        cout4, ovf4, prop4;

   int checks = 0;
   int errors = 0;

   nibble_serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(cin16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .sum(sum16), .cout(cout16), .ovf(ovf16), .all_prop(prop16)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4), .ovf(ovf4), .all_prop(prop4)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        prop;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer addition, result packed as {cout, ovf, all_prop, sum}.
   function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic cin);
      logic [16:0] s;
      logic [15:0] mask;
      logic        sa, sb, ss, co, ov, pr;
      mask = (w == 16) ? 16'hFFFF : 16'h000F;
      s    = {1'b0, a & mask} + {1'b0, b & mask} + {16'd0, cin};
      co   = s[w];
      sa   = a[w-1];
      sb   = b[w-1];
      ss   = s[w-1];
      ov   = (sa == sb) && (ss != sa);
      pr   = &((a ^ b) | ~mask);
      return {13'd0, co, ov, pr, s[15:0] & mask};
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      int lat;
      in_valid16 = 1'b1;
      a16 = v.a; b16 = v.b; cin16 = v.cin;
      check({tag, " in_ready"}, 32'(in_ready16), 32'd1);
      tick();
      in_valid16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      lat = 0;
      while (!out_valid16 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " sum"}, 32'(sum16), 32'(v.sum));
      check({tag, " cout"}, 32'(cout16), 32'(v.cout));
      check({tag, " ovf"}, 32'(ovf16), 32'(v.ovf));
      check({tag, " all_prop"}, 32'(prop16), 32'(v.prop));
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
      check({tag, " out_valid drop"}, 32'(out_valid16), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready16), 32'd1);
   endtask

   // Scoreboard for the random phase
   logic [31:0] q16[$];
   logic [31:0] q4[$];
   int acc16 = 0, acc4 = 0, xfer16 = 0, xfer4 = 0;
   bit mon_on = 1'b0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (in_valid16 && in_ready16) begin
            q16.push_back(model(16, a16, b16, cin16));
            acc16++;
         end
         if (out_valid16 && out_ready16) begin
            xfer16++;
            if (q16.size() == 0) check("rand16 extra transfer", 32'd1, 32'd0);
            else check("rand16 result", {13'd0, cout16, ovf16, prop16, sum16}, q16.pop_front());
         end
         if (in_valid4 && in_ready4) begin
            q4.push_back(model(4, {12'd0, a4}, {12'd0, b4}, cin4));
            acc4++;
         end
         if (out_valid4 && out_ready4) begin
            xfer4++;
            if (q4.size() == 0) check("rand4 extra transfer", 32'd1, 32'd0);
            else check("rand4 result", {13'd0, cout4, ovf4, prop4, 12'd0, sum4}, q4.pop_front());
         end
      end
   end

   vec_t vecs[6];

   initial begin
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
      in_valid4  = 1'b0; out_ready4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
      tick(); tick(); tick();
      check("reset in_ready", 32'(in_ready16), 32'd1);
      check("reset out_valid", 32'(out_valid16), 32'd0);
      check("reset sum", 32'(sum16), 32'd0);
      check("reset cout", 32'(cout16), 32'd0);
      check("reset ovf", 32'(ovf16), 32'd0);
      check("reset all_prop", 32'(prop16), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: hold DONE with out_ready low while in_valid toggles
      in_valid16 = 1'b1; a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0;
      tick();
      in_valid16 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("bp out_valid", 32'(out_valid16), 32'd1);
      for (int i = 0; i < 5; i++) begin
         in_valid16 = ~in_valid16;
         a16 = 16'($urandom); b16 = 16'($urandom);
         tick();
         check("bp hold out_valid", 32'(out_valid16), 32'd1);
         check("bp hold in_ready", 32'(in_ready16), 32'd0);
         check("bp hold sum", 32'(sum16), 32'h5555);
      end
      in_valid16 = 1'b0;
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
      check("bp transfer out_valid", 32'(out_valid16), 32'd0);
      check("bp transfer in_ready", 32'(in_ready16), 32'd1);
      tick();
      check("bp single transfer", 32'(out_valid16), 32'd0);
      check("idle keeps sum", 32'(sum16), 32'h5555);

      // Reset two cycles into RUN discards the op
      in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
      tick();
      in_valid16 = 1'b0;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check("midrun rst in_ready", 32'(in_ready16), 32'd1);
      check("midrun rst out_valid", 32'(out_valid16), 32'd0);
      check("midrun rst sum", 32'(sum16), 32'd0);
      check("midrun rst flags", {29'd0, cout16, ovf16, prop16}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("midrun no out_valid", 32'(out_valid16), 32'd0);
      end
      run_op('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0}, "after_rst");

      // Random back-to-back traffic on both widths
      mon_on = 1'b1;
      fork
         begin
            int cyc = 0;
            while (acc16 < 1000 && cyc < 30000) begin
               in_valid16  = ($urandom_range(0, 3) != 0);
               a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
               out_ready16 = ($urandom_range(0, 3) != 0);
               tick();
               cyc++;
            end
            in_valid16 = 1'b0;
            out_ready16 = 1'b1;
            cyc = 0;
            while ((q16.size() != 0 || out_valid16) && cyc < 50) begin
               tick();
               cyc++;
            end
         end
         begin
            int cyc = 0;
            while (acc4 < 1000 && cyc < 30000) begin
               in_valid4  = ($urandom_range(0, 3) != 0);
               a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
               out_ready4 = ($urandom_range(0, 3) != 0);
               tick();
               cyc++;
            end
            in_valid4 = 1'b0;
            out_ready4 = 1'b1;
            cyc = 0;
            while ((q4.size() != 0 || out_valid4) && cyc < 50) begin
               tick();
               cyc++;
            end
         end
      join
      tick();
      mon_on = 1'b0;
      check("rand16 accepted", 32'(acc16), 32'd1000);
      check("rand4 accepted", 32'(acc4), 32'd1000);
      check("rand16 transfers", 32'(xfer16), 32'(acc16));
      check("rand4 transfers", 32'(xfer4), 32'(acc4));
      check("rand16 pending", 32'(q16.size()), 32'd0);
      check("rand4 pending", 32'(q4.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
